cycle_config_sequencer: RTL

Sequencer that owns the backend cycle controller's configuration bus and timer enable. The host writes a 10-word shadow register file, then issues a commit. The block stops the backend timer and streams the shadow words over the backend config port. It then runs the backend for a programmed number of update cycles, or continuously, and reports completion. It sits between the host register interface and the backend cycle controller. The top level drives the backend's active-low reset with the inverse of `reset`.

---
 rtl/cycle_config_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cycle_config_sequencer.sv
// cycle_config_sequencer
//
// Owns the backend cycle controller's configuration bus and timer enable.
// The host fills a 10-word shadow file, then requests a commit. The block
// stops the backend timer, streams the shadow words over the config port,
// runs the backend for run_count update cycles (0 = until abort) and pulses
// done when the commit ends.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   host_wr_en/addr/wdata   shadow write port (accepted only while idle)
//   host_wr_err             one-cycle pulse after a rejected write
//   commit_req/commit_ack   level request / one-cycle accept pulse
//   run_count               update cycles per commit, latched at accept
//   abort                   ends the current commit through DONE
//   update_cycle_complete   completion indication from the backend
//   write_config_n, config_address, config_data   backend config port
//   timer_enable            backend timer enable
//   busy, done, cycles_done status
//
// Every output is a register loaded from the next-state decode, so the
// output values line up with the state the machine is in during that cycle.
module cycle_config_sequencer #(
  parameter int NUM_CONFIG_WORDS = 10,
  parameter int RUN_COUNT_WIDTH  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       host_wr_en,
  input  logic [5:0]                 host_addr,
  input  logic [15:0]                host_wdata,
  output logic                       host_wr_err,
  input  logic                       commit_req,
  output logic                       commit_ack,
  input  logic [RUN_COUNT_WIDTH-1:0] run_count,
  input  logic                       abort,
  input  logic                       update_cycle_complete,
  output logic                       write_config_n,
  output logic [5:0]                 config_address,
  output logic [15:0]                config_data,
  output logic                       timer_enable,
  output logic                       busy,
  output logic                       done,
  output logic [RUN_COUNT_WIDTH-1:0] cycles_done
);

  localparam int             IDX_W      = $clog2(NUM_CONFIG_WORDS);
  localparam logic [5:0]     NUM_WORDS  = 6'(NUM_CONFIG_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONFIG_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_STOP, S_LOAD, S_ARM, S_RUN, S_RESTART, S_DONE
  } state_t;

  state_t                     state, next_state;
  logic [IDX_W-1:0]           load_idx, next_load_idx;
  logic [15:0]                shadow [NUM_CONFIG_WORDS];
  logic [RUN_COUNT_WIDTH-1:0] run_target;
  logic [RUN_COUNT_WIDTH-1:0] cycles_inc;
  logic                       uc_prev;
  logic                       cycle_event;
  logic                       accept;
  logic                       addr_ok;
  logic                       skip_run;

  assign accept      = (state == S_IDLE) && commit_req;
  assign addr_ok     = host_addr < NUM_WORDS;
  // Rising edge of the backend completion, counted only while running.
  assign cycle_event = (state == S_RUN) && update_cycle_complete && !uc_prev;
  assign cycles_inc  = cycles_done + RUN_COUNT_WIDTH'(1);
  // Words 4 and 5 both zero means the loaded configuration has nothing to run.
  assign skip_run    = (shadow[4] == 16'h0000) && (shadow[5] == 16'h0000);

  // NOTE: every signal driven here gets a default first so no path through
  // the case leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state    = state;
    next_load_idx = load_idx;
    unique case (state)
      S_IDLE:    if (commit_req) next_state = S_STOP;
      S_STOP: begin
        next_state    = S_LOAD;
        next_load_idx = '0;
      end
      S_LOAD: begin
        if (load_idx == LAST_IDX) next_state = skip_run ? S_DONE : S_ARM;
        else                      next_load_idx = load_idx + IDX_W'(1);
      end
      S_ARM:     next_state = S_RUN;
      S_RUN: begin
        if (cycle_event) begin
          if ((run_target != '0) && (cycles_inc == run_target)) next_state = S_DONE;
          else                                                   next_state = S_RESTART;
        end
      end
      S_RESTART: next_state = S_RUN;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    // Abort overrides any transition, including a same-cycle final event;
    // the event itself is still counted by the register process.
    if (abort && (state != S_IDLE) && (state != S_DONE)) next_state = S_DONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      load_idx       <= '0;
      uc_prev        <= 1'b0;
      run_target     <= '0;
      cycles_done    <= '0;
      host_wr_err    <= 1'b0;
      commit_ack     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      timer_enable   <= 1'b0;
      write_config_n <= 1'b1;
      config_address <= '0;
      config_data    <= '0;
      // NOTE: the shadow file is cleared on reset because a commit straight
      // after reset must load defined zeros, not leftover contents.
      for (int i = 0; i < NUM_CONFIG_WORDS; i++) shadow[i] <= '0;
    end else begin
      state    <= next_state;
      load_idx <= next_load_idx;
      uc_prev  <= update_cycle_complete;

      if (accept) begin
        run_target  <= run_count;
        cycles_done <= '0;
      end else if (cycle_event) begin
        cycles_done <= cycles_inc;
      end

      if (host_wr_en && (state == S_IDLE) && addr_ok)
        shadow[host_addr[IDX_W-1:0]] <= host_wdata;
      host_wr_err <= host_wr_en && !((state == S_IDLE) && addr_ok);

      commit_ack     <= (next_state == S_STOP);
      busy           <= (next_state != S_IDLE);
      done           <= (next_state == S_DONE);
      timer_enable   <= (next_state == S_ARM) || (next_state == S_RUN);
      write_config_n <= (next_state != S_LOAD);
      if (next_state == S_LOAD) begin
        config_address <= 6'(next_load_idx);
        config_data    <= shadow[next_load_idx];
      end
    end
  end

endmodule
